oa_sequencer: RTL and testbench

OA_SEQUENCER -- requirements
Module: oa_sequencer

---
 rtl/oa_pkg.sv | 41 ++++
 rtl/oa_sequencer.sv | 165 ++++++++++++++++
 tb/tb_oa_sequencer.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/oa_pkg.sv
// Shared constants, FSM state type and control-flag decode for oa_sequencer.
// Optional feature macro used by the sequencer: OA_SEQ_TIMEOUT_EN.
package oa_pkg;

  localparam int OA_WORD_LENGTH = 16;
  localparam int OA_BUS_SIZE    = 4 * OA_WORD_LENGTH;
  localparam int OA_HALF_WINDOW = 512;
  localparam int OA_NBEATS      = OA_HALF_WINDOW / 4;
  localparam int OA_TMO_LIMIT   = 256;

  typedef enum logic [2:0] {
    IDLE,
    REQ1,
    WAIT1,
    REQ2,
    WAIT2,
    SUM,
    OUT,
    DONE
  } state_t;

  typedef struct packed {
    logic busy;
    logic arvalid;
    logic rready;
    logic act;
    logic done;
  } ctl_t;

  function automatic ctl_t ctl_of(input state_t s);
    ctl_t c;
    c         = '0;
    c.busy    = (s != IDLE);
    c.arvalid = (s == REQ1) || (s == REQ2);
    c.rready  = (s == WAIT1) || (s == WAIT2);
    c.act     = (s == OUT);
    c.done    = (s == DONE);
    return c;
  endfunction

endpackage

// File: rtl/oa_sequencer.sv
// Overlap-add half-window sequencer: fetches paired beats, drives the datapath.
// Define OA_SEQ_TIMEOUT_EN to build the read-wait watchdog and err flag.
module oa_sequencer
  import oa_pkg::*;
#(
  parameter int WORD_LENGTH      = OA_WORD_LENGTH,
  parameter int BUS_SIZE         = 4 * WORD_LENGTH,
  parameter int HALF_WINDOW_SIZE = OA_HALF_WINDOW,
  parameter int ADDR_WIDTH       = 16
) (
  input  logic                  aclk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr1,
  input  logic [ADDR_WIDTH-1:0] base_addr2,
  output logic                  arvalid,
  input  logic                  arready,
  output logic [ADDR_WIDTH-1:0] araddr,
  input  logic                  rvalid,
  output logic                  rready,
  input  logic [BUS_SIZE-1:0]   rdata,
  output logic [BUS_SIZE-1:0]   dp_data_in,
  output logic                  dp_load,
  output logic                  dp_action,
  input  logic [BUS_SIZE-1:0]   dp_data_out,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [BUS_SIZE-1:0]   out_data,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int NB = HALF_WINDOW_SIZE / 4;
  localparam int BW = $clog2(NB + 1);
  localparam logic [BW-1:0] LAST = BW'(NB - 1);

  state_t                state;
  ctl_t                  ctl;
  logic [BW-1:0]         beat;
  logic [ADDR_WIDTH-1:0] base1;
  logic [ADDR_WIDTH-1:0] base2;
  logic                  expire;

  function automatic logic [ADDR_WIDTH-1:0] offs(input logic [BW-1:0] b);
    return ADDR_WIDTH'({b, 3'b000});
  endfunction

  assign busy      = ctl.busy;
  assign arvalid   = ctl.arvalid;
  assign rready    = ctl.rready;
  assign dp_action = ctl.act;
  assign out_valid = ctl.act;
  assign done      = ctl.done;
  assign out_data  = ctl.act ? dp_data_out : '0;
  assign dp_load   = rvalid && ctl.rready;

  always_comb begin
    dp_data_in = '0;
    if (dp_load) begin
      for (int i = 0; i < 4; i++) begin
        dp_data_in[i*WORD_LENGTH +: WORD_LENGTH] =
          rdata[i*WORD_LENGTH +: WORD_LENGTH];
      end
    end
  end

`ifdef OA_SEQ_TIMEOUT_EN
  logic [7:0] tmo;
  logic       err_q;

  assign expire = ctl.rready && !rvalid &&
                  (tmo == 8'(OA_TMO_LIMIT - 1));
  assign err    = err_q;

  always_ff @(posedge aclk) begin
    if (reset) begin
      tmo   <= '0;
      err_q <= 1'b0;
    end else begin
      if (ctl.rready && !rvalid && !expire)
        tmo <= tmo + 8'd1;
      else
        tmo <= '0;
      if (expire)
        err_q <= 1'b1;
      else if (state == IDLE && start)
        err_q <= 1'b0;
    end
  end
`else
  assign expire = 1'b0;
  assign err    = 1'b0;
`endif

  // araddr is loaded on entry to REQ1/REQ2 so it is stable for the handshake
  always_ff @(posedge aclk) begin
    if (reset) begin
      state  <= IDLE;
      ctl    <= '0;
      beat   <= '0;
      base1  <= '0;
      base2  <= '0;
      araddr <= '0;
    end else if (expire) begin
      state  <= DONE;
      ctl    <= ctl_of(DONE);
      araddr <= '0;
    end else begin
      unique case (state)
        IDLE: if (start) begin
          state  <= REQ1;
          ctl    <= ctl_of(REQ1);
          beat   <= '0;
          base1  <= base_addr1;
          base2  <= base_addr2;
          araddr <= base_addr1;
        end
        REQ1: if (arready) begin
          state  <= WAIT1;
          ctl    <= ctl_of(WAIT1);
          araddr <= '0;
        end
        WAIT1: if (rvalid) begin
          state  <= REQ2;
          ctl    <= ctl_of(REQ2);
          araddr <= base2 + offs(beat);
        end
        REQ2: if (arready) begin
          state  <= WAIT2;
          ctl    <= ctl_of(WAIT2);
          araddr <= '0;
        end
        WAIT2: if (rvalid) begin
          state <= SUM;
          ctl   <= ctl_of(SUM);
        end
        SUM: begin
          state <= OUT;
          ctl   <= ctl_of(OUT);
        end
        OUT: if (out_ready) begin
          if (beat == LAST) begin
            state <= DONE;
            ctl   <= ctl_of(DONE);
          end else begin
            state  <= REQ1;
            ctl    <= ctl_of(REQ1);
            beat   <= beat + 1'b1;
            araddr <= base1 + offs(beat + 1'b1);
          end
        end
        DONE: begin
          state <= IDLE;
          ctl   <= ctl_of(IDLE);
        end
        default: begin
          state <= IDLE;
          ctl   <= ctl_of(IDLE);
        end
      endcase
    end
  end

endmodule

// File: tb/tb_oa_sequencer.sv
// Bench for oa_sequencer with a behavioural memory and overlap-add datapath.
// Timeout scenario is built only when OA_SEQ_TIMEOUT_EN is defined.
module tb_oa_sequencer;
  import oa_pkg::*;

  localparam int NB = OA_NBEATS;

  logic        aclk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] base_addr1, base_addr2;
  logic        arvalid, arready;
  logic [15:0] araddr;
  logic        rvalid, rready;
  logic [63:0] rdata, dp_data_in, dp_data_out, out_data;
  logic        dp_load, dp_action;
  logic        out_valid, out_ready;
  logic        busy, done, err;

  always #5 aclk = ~aclk;

  oa_sequencer dut (
    .aclk(aclk), .reset(reset), .start(start),
    .base_addr1(base_addr1), .base_addr2(base_addr2),
    .arvalid(arvalid), .arready(arready), .araddr(araddr),
    .rvalid(rvalid), .rready(rready), .rdata(rdata),
    .dp_data_in(dp_data_in), .dp_load(dp_load),
    .dp_action(dp_action), .dp_data_out(dp_data_out),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .busy(busy), .done(done), .err(err)
  );

  logic const_mode = 1'b0;
  logic stall = 1'b0;
  logic ar_gap = 1'b0;
  logic bp_en = 1'b0;

  function automatic logic [63:0] mdata(input logic [15:0] a);
    if (const_mode)
      return (a < 16'h1000) ? {4{16'h0001}} : {4{16'h0002}};
    return {a + 16'd3, a + 16'd2, a + 16'd1, a};
  endfunction

  function automatic logic [63:0] lsum(input logic [63:0] x, y);
    logic [63:0] r;
    for (int i = 0; i < 4; i++)
      r[i*16 +: 16] = x[i*16 +: 16] + y[i*16 +: 16];
    return r;
  endfunction

  // overlap-add datapath model
  logic        pair;
  logic [63:0] hold1, sumr;
  assign dp_data_out = sumr;
  always @(posedge aclk) begin
    if (reset) begin
      pair <= 1'b0; hold1 <= '0; sumr <= '0;
    end else if (dp_load) begin
      if (!pair) begin
        hold1 <= dp_data_in; pair <= 1'b1;
      end else begin
        sumr <= lsum(hold1, dp_data_in); pair <= 1'b0;
      end
    end else if (dp_action) pair <= 1'b0;
  end

  // memory: one outstanding read
  logic        pend;
  logic [15:0] paddr;
  assign rvalid = pend && !stall;
  assign rdata  = rvalid ? mdata(paddr) : '0;
  always @(posedge aclk) begin
    if (reset) pend <= 1'b0;
    else begin
      if (rvalid && rready) pend <= 1'b0;
      if (arvalid && arready) begin
        pend <= 1'b1; paddr <= araddr;
      end
    end
  end

  // monitor
  logic [15:0] arq[$];
  logic [63:0] outq[$];
  int cyc = 0, nloads, last2, latbad, dcnt, obeat;
  int bp_n, bp_bad, ar_bad;
  logic [63:0] bp_snap;
  logic [15:0] ar_last;
  logic ov_prev, ar_wait, gap_t = 1'b0;
  initial begin arready = 1'b1; out_ready = 1'b1; end

  always @(negedge aclk) begin
    cyc++;
    gap_t   = ~gap_t;
    arready = !ar_gap || gap_t;
    if (bp_en && out_valid && obeat == 5 && bp_n < 10) begin
      if (bp_n > 0 && out_data !== bp_snap) bp_bad++;
      if (arvalid) bp_bad++;
      bp_snap   = out_data;
      bp_n++;
      out_ready = 1'b0;
    end else out_ready = 1'b1;
    if (ar_wait && (!arvalid || araddr !== ar_last)) ar_bad++;
    ar_wait = arvalid && !arready;
    ar_last = araddr;
    if (arvalid && arready) arq.push_back(araddr);
    if (dp_load) begin
      nloads++;
      if (nloads % 2 == 0) last2 = cyc;
    end
    if (out_valid && !ov_prev && (cyc - last2 != 2)) latbad++;
    ov_prev = out_valid;
    if (out_valid && out_ready) begin
      outq.push_back(out_data); obeat++;
    end
    if (done) dcnt++;
  end

  int total = 0, passed = 0;

  task automatic chk(input string nm, input logic [63:0] act, exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  task automatic launch(input logic [15:0] b1, b2);
    @(negedge aclk);
    arq.delete(); outq.delete();
    nloads = 0; last2 = -100; latbad = 0; dcnt = 0; obeat = 0;
    bp_n = 0; bp_bad = 0; ar_bad = 0; ov_prev = 1'b0;
    base_addr1 = b1; base_addr2 = b2; start = 1'b1;
    @(negedge aclk);
    start = 1'b0; base_addr1 = ~b1; base_addr2 = ~b2;
    @(negedge aclk);
    start = 1'b1;
    @(negedge aclk);
    start = 1'b0;
  endtask

  task automatic run(input logic [15:0] b1, b2);
    int n;
    launch(b1, b2);
    n = 0;
    while (dcnt == 0 && n < 5000) begin
      @(negedge aclk); n++;
    end
    chk("run_done", n < 5000, 1);
    repeat (2) @(negedge aclk);
  endtask

  task automatic full_check(input logic [15:0] b1, b2);
    int bo, ba;
    logic [15:0] a1, a2;
    bo = 0; ba = 0;
    chk("out_count", outq.size(), NB);
    chk("ar_count", arq.size(), 2 * NB);
    for (int b = 0; b < NB; b++) begin
      a1 = b1 + 16'(8 * b);
      a2 = b2 + 16'(8 * b);
      if (b >= outq.size() || outq[b] !== lsum(mdata(a1), mdata(a2))) bo++;
      if (2*b+1 >= arq.size() || arq[2*b] !== a1 || arq[2*b+1] !== a2) ba++;
    end
    chk("beat_sums", bo, 0);
    chk("ar_seq", ba, 0);
    chk("lat2", latbad, 0);
    chk("done_once", dcnt, 1);
    chk("err_low", err, 0);
    chk("idle_busy", busy, 0);
  endtask

  typedef struct {
    logic [15:0] b1, b2;
    int          pb;
    logic [15:0] ar1, ar2, s0;
  } vec_t;

  vec_t tbl[5];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1);
  end

  initial begin
    int n;
    tbl[0] = '{16'h0000, 16'h1000, 0,   16'h0000, 16'h1000, 16'h1000};
    tbl[1] = '{16'h0000, 16'h1000, 1,   16'h0008, 16'h1008, 16'h1010};
    tbl[2] = '{16'h0000, 16'h1000, 127, 16'h03F8, 16'h13F8, 16'h17F0};
    tbl[3] = '{16'hFFF8, 16'h2000, 1,   16'h0000, 16'h2008, 16'h2008};
    tbl[4] = '{16'h0040, 16'h0040, 2,   16'h0050, 16'h0050, 16'h00A0};

    reset = 1'b1; start = 1'b0; base_addr1 = '0; base_addr2 = '0;
    repeat (2) @(negedge aclk);
    chk("reset_ctl",
        {arvalid, rready, dp_load, dp_action, out_valid, busy, done, err}, 0);
    chk("reset_data", {48'h0, araddr} | out_data | dp_data_in, 0);
    reset = 1'b0;

    for (int i = 0; i < 5; i++) begin
      run(tbl[i].b1, tbl[i].b2);
      chk($sformatf("v%0d_ar1", i), arq[2*tbl[i].pb], tbl[i].ar1);
      chk($sformatf("v%0d_ar2", i), arq[2*tbl[i].pb+1], tbl[i].ar2);
      chk($sformatf("v%0d_sum0", i), outq[tbl[i].pb][15:0], tbl[i].s0);
      full_check(tbl[i].b1, tbl[i].b2);
    end

    const_mode = 1'b1;
    run(16'h0000, 16'h1000);
    chk("const_sum", outq[0], {4{16'h0003}});
    full_check(16'h0000, 16'h1000);
    const_mode = 1'b0;

    bp_en = 1'b1; ar_gap = 1'b1;
    run(16'h0100, 16'h2100);
    chk("bp_cycles", bp_n, 10);
    chk("bp_stable", bp_bad, 0);
    chk("ar_stable", ar_bad, 0);
    full_check(16'h0100, 16'h2100);
    bp_en = 1'b0; ar_gap = 1'b0;

    launch(16'h0000, 16'h1000);
    n = 0;
    while (!(obeat == 40 && rready && arq.size() == 82) && n < 3000) begin
      @(negedge aclk); n++;
    end
    chk("reach_wait2_b40", n < 3000, 1);
    reset = 1'b1;
    @(negedge aclk);
    chk("midreset_ctl",
        {arvalid, rready, dp_load, dp_action, out_valid, busy, done, err}, 0);
    chk("midreset_data", {48'h0, araddr} | out_data | dp_data_in, 0);
    reset = 1'b0;
    run(16'h0000, 16'h1000);
    chk("after_reset_b0", outq[0], lsum(mdata(16'h0000), mdata(16'h1000)));
    full_check(16'h0000, 16'h1000);

`ifdef OA_SEQ_TIMEOUT_EN
    stall = 1'b1;
    run(16'h0000, 16'h1000);
    chk("tmo_err", err, 1);
    chk("tmo_done", dcnt, 1);
    chk("tmo_idle", busy, 0);
    chk("tmo_nout", outq.size(), 0);
    stall = 1'b0;
    run(16'h0000, 16'h1000);
    full_check(16'h0000, 16'h1000);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
